rv_muldiv_unit: RTL and testbench

Parametrised multi-cycle RV32M/RV64M multiply/divide execution unit that sits beside the combinational ALU in the execute stage.
- Implements all eight M-extension ops, including DIV/DIVU/REM/REMU, which the single-cycle ALU does not provide.
- Multiply uses one registered compute cycle.
- Divide uses an iterative radix-2 restoring divider.
- Valid/ready handshakes on input and output let the pipeline stall on the result.

---
 rtl/rv_muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// ============================================================================
// Module   : rv_muldiv_unit
// Brief    : RV32M/RV64M multi-cycle multiply/divide unit with valid/ready
//            handshakes; single-cycle registered multiply, radix-2 restoring
//            divide. MULDIV_FAST_SPECIAL_EN lets divide-by-zero and signed
//            overflow skip the iterative divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ones = {XLEN{1'b1}};

    logic [1:0]      r_state;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_quot;      // multiplicand during MUL, dividend/quotient during DIV
    logic [XLEN-1:0] r_divisor;   // multiplier during MUL, divisor magnitude during DIV
    logic [XLEN:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_special;
    logic [XLEN-1:0] r_special_val;
    logic [XLEN-1:0] r_result;

    // Operand preparation at accept
    logic            w_accept;
    logic            w_signed_div;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_val;

    assign w_accept      = in_valid & in_ready;
    assign w_signed_div  = ~op[0];
    assign w_a_neg       = w_signed_div & a[XLEN-1];
    assign w_b_neg       = w_signed_div & b[XLEN-1];
    assign w_abs_a       = w_a_neg ? (~a + 1'b1) : a;
    assign w_abs_b       = w_b_neg ? (~b + 1'b1) : b;
    assign w_b_zero      = (b == '0);
    assign w_ovf         = w_signed_div & (a == c_min) & (b == c_ones);
    assign w_special_val = w_b_zero ? (op[1] ? a : c_ones)
                                    : (op[1] ? '0 : a);

    // Multiply: sign-extend to 2*XLEN so one unsigned product covers all forms
    logic              w_sa;
    logic              w_sb;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;

    assign w_sa    = (r_op != 2'b11);
    assign w_sb    = ~r_op[1];
    assign w_a_ext = {{XLEN{w_sa & r_quot[XLEN-1]}}, r_quot};
    assign w_b_ext = {{XLEN{w_sb & r_divisor[XLEN-1]}}, r_divisor};
    assign w_prod  = w_a_ext * w_b_ext;

    // One restoring-divide step
    logic [XLEN+1:0] w_rem_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_borrow;
    logic [XLEN:0]   w_rem_next;
    logic [XLEN-1:0] w_quot_next;
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_rem_shift - {2'b00, r_divisor};
    assign w_borrow    = w_diff[XLEN+1];
    assign w_rem_next  = w_borrow ? w_rem_shift[XLEN:0] : w_diff[XLEN:0];
    assign w_quot_next = {r_quot[XLEN-2:0], ~w_borrow};
    assign w_quot_fix  = r_neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_rem_fix   = r_neg_r ? (~w_rem_next[XLEN-1:0] + 1'b1) : w_rem_next[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_op          <= '0;
            r_quot        <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_result      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_op          <= op[1:0];
                        r_quot        <= op[2] ? w_abs_a : a;
                        r_divisor     <= op[2] ? w_abs_b : b;
                        r_rem         <= '0;
                        r_cnt         <= CNT_W'(XLEN);
                        r_neg_q       <= w_a_neg ^ w_b_neg;
                        r_neg_r       <= w_a_neg;
                        r_special     <= w_b_zero | w_ovf;
                        r_special_val <= w_special_val;
                        if (!op[2]) begin
                            r_state <= c_mul;
                        end else begin
`ifdef MULDIV_FAST_SPECIAL_EN
                            if (w_b_zero | w_ovf) begin
                                r_result <= w_special_val;
                                r_state  <= c_done;
                            end else begin
                                r_state  <= c_div;
                            end
`else
                            r_state <= c_div;
`endif
                        end
                    end
                end
                c_mul: begin
                    if (flush) begin
                        r_state <= c_idle;
                    end else begin
                        r_result <= (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                        r_state  <= c_done;
                    end
                end
                c_div: begin
                    if (flush) begin
                        r_state <= c_idle;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt - 1'b1;
                        // Last quotient bit is formed and sign-corrected on the same edge
                        if (r_cnt == CNT_W'(1)) begin
                            r_result <= r_special ? r_special_val
                                                  : (r_op[1] ? w_rem_fix : w_quot_fix);
                            r_state  <= c_done;
                        end
                    end
                end
                default: begin
                    if (flush || out_ready) begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle) & ~rst;
    assign out_valid = (r_state == c_done);
    assign busy      = (r_state != c_idle);
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_rv_muldiv_unit.sv
// ============================================================================
// Module   : tb_rv_muldiv_unit
// Brief    : Directed self-checking bench for rv_muldiv_unit (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_asserts = 0;
    int n_fail    = 0;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Edges counted include the accept edge
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        issue(o, x, y);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_in_ready_held", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Multiply forms
        run_op("mul",    3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 2);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 2);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'h2, 32'h00000001, 2);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 2);
        run_op("mulhu_big", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 2);

        // Divide forms
        run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("divu_7_2",  3'b101, 32'd7, 32'd2, 32'd3, 33);
        run_op("div_20_m3", 3'b100, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33);
        run_op("rem_20_m3", 3'b110, 32'd20, 32'hFFFFFFFD, 32'd2, 33);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Special cases
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, SPEC_LAT);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, SPEC_LAT);
        run_op("div_by0",  3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, SPEC_LAT);
        run_op("rem_by0",  3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, SPEC_LAT);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPEC_LAT);

        // Backpressure in DONE
        issue(3'b000, 32'd6, 32'd7);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(result), 64'd42);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        run_op("bp_next_mul", 3'b000, 32'd3, 32'd5, 32'd15, 2);

        // Flush mid-divide: no result may appear afterwards
        issue(3'b101, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("flush_div_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_valid", 64'(out_valid), 64'd0);
        check("flush_div_busy", 64'(busy), 64'd0);
        check("flush_div_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_div_no_result", 64'(seen), 64'd0);

        // Flush together with out_ready in DONE
        issue(3'b000, 32'd2, 32'd2);
        wait_done(lat);
        check("flush_done_valid_before", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done_valid", 64'(out_valid), 64'd0);
        check("flush_done_busy", 64'(busy), 64'd0);
        run_op("after_flush_mul", 3'b000, 32'd3, 32'd4, 32'd12, 2);

        // Reset mid-divide
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        check("rstdiv_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstdiv_out_valid", 64'(out_valid), 64'd0);
        check("rstdiv_in_ready", 64'(in_ready), 64'd1);
        check("rstdiv_result", 64'(result), 64'd0);
        check("rstdiv_busy", 64'(busy), 64'd0);
        @(negedge clk);
        run_op("rstdiv_next", 3'b101, 32'd7, 32'd2, 32'd3, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
